input_arbiter: RTL and testbench

INPUT_ARBITER -- requirements
Module: input_arbiter

---
 rtl/input_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_input_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : input_arbiter
//  Purpose  : Round-robin packet arbiter. Pops whole packets from a set of
//             fall-through input FIFOs and streams them, one word per cycle,
//             onto a single registered output port. A grant is held from the
//             first header word until end-of-packet (no preemption).
//  Options  : define IN_ARB_STALL_CNT_EN to build the 32-bit saturating
//             stall counter; otherwise stall_cnt is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module input_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_QUEUES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_empty,
  output logic [NUM_QUEUES-1:0]            in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             state,
  output logic                             eop,
  output logic [31:0]                      stall_cnt
);

  localparam int c_GRANT_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_IN_PKT = 1'b1;

  // Reset value puts the round-robin pointer on the last queue so that the
  // first search after reset starts at queue 0.
  localparam logic [c_GRANT_W-1:0] c_GRANT_RST = c_GRANT_W'(NUM_QUEUES - 1);

  // FSM state
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;

  // The held grant doubles as the round-robin pointer (last_grant): the
  // two values are only ever written together, so one register serves both.
  logic [c_GRANT_W-1:0]  r_grant;
  logic                  r_payload_seen;

  // Arbitration and datapath wires
  logic                  w_found;
  logic [c_GRANT_W-1:0]  w_rr_sel;
  logic [c_GRANT_W-1:0]  w_src;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [CTRL_WIDTH-1:0] w_src_ctrl;
  logic                  w_ctrl_zero;
  logic                  w_pop;
  logic                  w_eop;
  logic [NUM_QUEUES-1:0] w_rd_en;

  // Output registers
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic                  r_out_wr;
  logic                  r_eop;

  // Round-robin search: first non-empty queue after the last grant.
  always_comb begin
    int v_idx;
    w_found  = 1'b0;
    w_rr_sel = r_grant;
    v_idx    = 0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      v_idx = (int'(r_grant) + k) % NUM_QUEUES;
      if (!w_found && !in_empty[c_GRANT_W'(v_idx)]) begin
        w_found  = 1'b1;
        w_rr_sel = c_GRANT_W'(v_idx);
      end
    end
  end

  // Source queue for this cycle: the fresh pick while idle, the held grant
  // while a packet is in flight; mux its head word and ctrl.
  always_comb begin
    w_src       = (r_state == c_ST_IDLE) ? w_rr_sel : r_grant;
    w_src_data  = in_data[int'(w_src)*DATA_WIDTH +: DATA_WIDTH];
    w_src_ctrl  = in_ctrl[int'(w_src)*CTRL_WIDTH +: CTRL_WIDTH];
    w_ctrl_zero = (w_src_ctrl == '0);
  end

  // Pop decision and end-of-packet detection; nothing pops during reset.
  always_comb begin
    w_pop = 1'b0;
    if (!reset && out_rdy) begin
      if (r_state == c_ST_IDLE) begin
        w_pop = w_found;
      end else begin
        w_pop = !in_empty[r_grant];
      end
    end
    // The flag is always clear in IDLE, so an eop can only come from IN_PKT.
    w_eop = w_pop && r_payload_seen && !w_ctrl_zero;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: enter IN_PKT on a grant, leave on end-of-packet. The
  // exit lands in IDLE so a new grant cannot happen in the eop cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_pop) begin
          w_state_nxt = c_ST_IN_PKT;
        end
      end
      c_ST_IN_PKT: begin
        if (w_eop) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs: one-hot pop strobe on the source queue.
  always_comb begin
    w_rd_en = '0;
    if (w_pop) begin
      w_rd_en[w_src] = 1'b1;
    end
  end

  // Grant register: captured on the idle-state grant, held for the packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= c_GRANT_RST;
    end else if (r_state == c_ST_IDLE && w_pop) begin
      r_grant <= w_rr_sel;
    end
  end

  // Payload-seen flag: set by a zero-ctrl pop, cleared by end-of-packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_payload_seen <= 1'b0;
    end else if (w_eop) begin
      r_payload_seen <= 1'b0;
    end else if (w_pop && w_ctrl_zero) begin
      r_payload_seen <= 1'b1;
    end
  end

  // Output stage: one-cycle registered copy of each popped word; data and
  // ctrl hold their previous value when nothing is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
      r_out_ctrl <= '0;
      r_out_wr   <= 1'b0;
      r_eop      <= 1'b0;
    end else begin
      r_out_wr <= w_pop;
      r_eop    <= w_eop;
      if (w_pop) begin
        r_out_data <= w_src_data;
        r_out_ctrl <= w_src_ctrl;
      end
    end
  end

`ifdef IN_ARB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Stall counter: cycles spent mid-packet with downstream back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_state == c_ST_IN_PKT && !out_rdy && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign in_rd_en = w_rd_en;
  assign out_data = r_out_data;
  assign out_ctrl = r_out_ctrl;
  assign out_wr   = r_out_wr;
  assign eop      = r_eop;
  assign state    = r_state[0];

endmodule
`default_nettype wire

// File: tb/tb_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_arbiter
//  Purpose  : Directed self-checking bench for input_arbiter (4 queues,
//             64-bit data). Models the fall-through input FIFOs and checks
//             outputs against hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_arbiter;

  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int CW = 8;

`ifdef IN_ARB_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic             clk;
  logic             reset;
  logic [NQ*DW-1:0] in_data;
  logic [NQ*CW-1:0] in_ctrl;
  logic [NQ-1:0]    in_empty;
  logic [NQ-1:0]    in_rd_en;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic             state;
  logic             eop;
  logic [31:0]      stall_cnt;

  int errors = 0;
  int checks = 0;

  // Input FIFO model: {ctrl, data} words with read/write pointers.
  logic [CW+DW-1:0] mem [0:NQ-1][0:15];
  int               rd_ptr [0:NQ-1];
  int               wr_ptr [0:NQ-1];

  input_arbiter #(
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .NUM_QUEUES(NQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .state     (state),
    .eop       (eop),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dv(input int q, input int k);
    return 64'hA5A5_0000_0000_0000 | (64'(q) << 8) | 64'(k);
  endfunction

  task automatic refresh();
    for (int i = 0; i < NQ; i++) begin
      if (rd_ptr[i] == wr_ptr[i]) begin
        in_empty[i]          = 1'b1;
        in_data[i*DW +: DW]  = '0;
        in_ctrl[i*CW +: CW]  = '0;
      end else begin
        in_empty[i]          = 1'b0;
        in_data[i*DW +: DW]  = mem[i][rd_ptr[i]][DW-1:0];
        in_ctrl[i*CW +: CW]  = mem[i][rd_ptr[i]][CW+DW-1:DW];
      end
    end
  endtask

  task automatic push(input int q, input logic [CW-1:0] c, input logic [DW-1:0] d);
    mem[q][wr_ptr[q]] = {c, d};
    wr_ptr[q]++;
    refresh();
  endtask

  // One clock: latch the pop strobes at the edge, apply them to the FIFO
  // model just after, and leave the caller 2 time units past the edge.
  task automatic tick();
    logic [NQ-1:0] rd;
    @(posedge clk);
    rd = in_rd_en;
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (rd[i] && rd_ptr[i] != wr_ptr[i]) rd_ptr[i]++;
    end
    refresh();
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < NQ; i++) begin
      rd_ptr[i] = 0;
      wr_ptr[i] = 0;
    end
    refresh();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", out_wr); end
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b want 0", eop); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", out_ctrl); end
    checks++; if (state !== 1'b0) begin errors++; $display("FAIL rst_state: got %b want 0", state); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    checks++; if (in_rd_en !== 4'b0000) begin errors++; $display("FAIL rst_rden: got %b want 0000", in_rd_en); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single_packet();
    logic [CW-1:0] cexp [0:3];
    logic          ex;
    cexp[0] = 8'hFF; cexp[1] = 8'h00; cexp[2] = 8'h00; cexp[3] = 8'h01;
    do_reset();
    for (int k = 0; k < 4; k++) push(0, cexp[k], dv(0, k));
    #1;
    checks++; if (in_rd_en !== 4'b0001) begin errors++; $display("FAIL sp_grant: got %b want 0001", in_rd_en); end
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++; if (out_wr !== 1'b1) begin errors++; $display("FAIL sp_wr%0d: got %b want 1", t, out_wr); end
      checks++; if (out_data !== dv(0, t-1)) begin errors++; $display("FAIL sp_data%0d: got %h want %h", t, out_data, dv(0, t-1)); end
      checks++; if (out_ctrl !== cexp[t-1]) begin errors++; $display("FAIL sp_ctrl%0d: got %h want %h", t, out_ctrl, cexp[t-1]); end
      ex = (t == 4);
      checks++; if (eop !== ex) begin errors++; $display("FAIL sp_eop%0d: got %b want %b", t, eop, ex); end
      ex = (t != 4);
      checks++; if (state !== ex) begin errors++; $display("FAIL sp_state%0d: got %b want %b", t, state, ex); end
    end
    tick();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL sp_idle_wr: got %b want 0", out_wr); end
    checks++; if (out_data !== dv(0, 3)) begin errors++; $display("FAIL sp_hold: got %h want %h", out_data, dv(0, 3)); end
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL sp_idle_eop: got %b want 0", eop); end
  endtask

  task automatic test_round_robin();
    int   q;
    int   k;
    logic ex;
    do_reset();
    for (int i = 0; i < NQ; i++) begin
      push(i, 8'hFF, dv(i, 0));
      push(i, 8'h00, dv(i, 1));
      push(i, 8'h01, dv(i, 2));
    end
    #1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      q = (t - 1) / 3;
      k = (t - 1) % 3;
      checks++; if (out_wr !== 1'b1) begin errors++; $display("FAIL rr_wr%0d: got %b want 1", t, out_wr); end
      checks++; if (out_data !== dv(q, k)) begin errors++; $display("FAIL rr_data%0d: got %h want %h", t, out_data, dv(q, k)); end
      ex = (k == 2);
      checks++; if (eop !== ex) begin errors++; $display("FAIL rr_eop%0d: got %b want %b", t, eop, ex); end
      ex = (k != 2);
      checks++; if (state !== ex) begin errors++; $display("FAIL rr_state%0d: got %b want %b", t, state, ex); end
    end
    tick();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rr_done_wr: got %b want 0", out_wr); end
    checks++; if (state !== 1'b0) begin errors++; $display("FAIL rr_done_state: got %b want 0", state); end
  endtask

  task automatic test_stall();
    do_reset();
    push(2, 8'hFF, dv(2, 0));
    push(2, 8'h00, dv(2, 1));
    push(2, 8'h00, dv(2, 2));
    push(2, 8'h00, dv(2, 3));
    push(2, 8'h01, dv(2, 4));
    #1;
    tick();
    checks++; if (out_data !== dv(2, 0)) begin errors++; $display("FAIL st_w0: got %h want %h", out_data, dv(2, 0)); end
    tick();
    checks++; if (out_data !== dv(2, 1)) begin errors++; $display("FAIL st_w1: got %h want %h", out_data, dv(2, 1)); end
    out_rdy = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      checks++; if (in_rd_en !== 4'b0000) begin errors++; $display("FAIL st_rden%0d: got %b want 0000", s, in_rd_en); end
      tick();
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL st_wr%0d: got %b want 0", s, out_wr); end
      checks++; if (state !== 1'b1) begin errors++; $display("FAIL st_state%0d: got %b want 1", s, state); end
    end
    checks++; if (stall_cnt !== EXP_STALL) begin errors++; $display("FAIL st_cnt: got %0d want %0d", stall_cnt, EXP_STALL); end
    out_rdy = 1'b1;
    #1;
    checks++; if (in_rd_en !== 4'b0100) begin errors++; $display("FAIL st_resume: got %b want 0100", in_rd_en); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++; if (out_data !== dv(2, k)) begin errors++; $display("FAIL st_drain%0d: got %h want %h", k, out_data, dv(2, k)); end
    end
    checks++; if (eop !== 1'b1) begin errors++; $display("FAIL st_eop: got %b want 1", eop); end
  endtask

  task automatic test_late_header();
    logic ex;
    do_reset();
    push(1, 8'hFF, dv(1, 0));
    push(3, 8'hFF, dv(3, 0));
    push(3, 8'h00, dv(3, 1));
    push(3, 8'h01, dv(3, 2));
    #1;
    checks++; if (in_rd_en !== 4'b0010) begin errors++; $display("FAIL lh_grant: got %b want 0010", in_rd_en); end
    tick();
    checks++; if (out_data !== dv(1, 0)) begin errors++; $display("FAIL lh_h0: got %h want %h", out_data, dv(1, 0)); end
    for (int s = 0; s < 3; s++) begin
      checks++; if (in_rd_en !== 4'b0000) begin errors++; $display("FAIL lh_wait_rden%0d: got %b want 0000", s, in_rd_en); end
      tick();
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL lh_wait_wr%0d: got %b want 0", s, out_wr); end
    end
    push(1, 8'hFF, dv(1, 1));
    push(1, 8'h00, dv(1, 2));
    push(1, 8'h01, dv(1, 3));
    #1;
    checks++; if (in_rd_en !== 4'b0010) begin errors++; $display("FAIL lh_hold: got %b want 0010", in_rd_en); end
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++; if (out_data !== dv(1, t)) begin errors++; $display("FAIL lh_data%0d: got %h want %h", t, out_data, dv(1, t)); end
      ex = (t == 3);
      checks++; if (eop !== ex) begin errors++; $display("FAIL lh_eop%0d: got %b want %b", t, eop, ex); end
    end
    checks++; if (in_rd_en !== 4'b1000) begin errors++; $display("FAIL lh_next: got %b want 1000", in_rd_en); end
    tick();
    checks++; if (out_data !== dv(3, 0)) begin errors++; $display("FAIL lh_q3: got %h want %h", out_data, dv(3, 0)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(1, 8'hFF, dv(1, 0));
    push(1, 8'h00, dv(1, 1));
    push(1, 8'h00, dv(1, 2));
    push(1, 8'h00, dv(1, 3));
    push(1, 8'h01, dv(1, 4));
    #1;
    tick();
    tick();
    checks++; if (out_data !== dv(1, 1)) begin errors++; $display("FAIL rm_p1: got %h want %h", out_data, dv(1, 1)); end
    reset = 1'b1;
    push(0, 8'hFF, dv(0, 0));
    push(0, 8'h00, dv(0, 1));
    push(0, 8'h01, dv(0, 2));
    #1;
    checks++; if (in_rd_en !== 4'b0000) begin errors++; $display("FAIL rm_rden: got %b want 0000", in_rd_en); end
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rm_wr%0d: got %b want 0", s, out_wr); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rm_data%0d: got %h want 0", s, out_data); end
      checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL rm_ctrl%0d: got %h want 0", s, out_ctrl); end
      checks++; if (eop !== 1'b0) begin errors++; $display("FAIL rm_eop%0d: got %b want 0", s, eop); end
      checks++; if (state !== 1'b0) begin errors++; $display("FAIL rm_state%0d: got %b want 0", s, state); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_stall%0d: got %0d want 0", s, stall_cnt); end
      checks++; if (in_rd_en !== 4'b0000) begin errors++; $display("FAIL rm_rden_rst%0d: got %b want 0000", s, in_rd_en); end
    end
    reset = 1'b0;
    #1;
    checks++; if (in_rd_en !== 4'b0001) begin errors++; $display("FAIL rm_regrant: got %b want 0001", in_rd_en); end
    tick();
    checks++; if (out_data !== dv(0, 0)) begin errors++; $display("FAIL rm_q0: got %h want %h", out_data, dv(0, 0)); end
    checks++; if (state !== 1'b1) begin errors++; $display("FAIL rm_q0_state: got %b want 1", state); end
  endtask

  task automatic test_back_to_back();
    logic ex;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      push(3, 8'hFF, dv(3, 3*p));
      push(3, 8'h00, dv(3, 3*p + 1));
      push(3, 8'h01, dv(3, 3*p + 2));
    end
    #1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++; if (out_wr !== 1'b1) begin errors++; $display("FAIL bb_wr%0d: got %b want 1", t, out_wr); end
      checks++; if (out_data !== dv(3, t-1)) begin errors++; $display("FAIL bb_data%0d: got %h want %h", t, out_data, dv(3, t-1)); end
      ex = (t == 3 || t == 6);
      checks++; if (eop !== ex) begin errors++; $display("FAIL bb_eop%0d: got %b want %b", t, eop, ex); end
      ex = !(t == 3 || t == 6);
      checks++; if (state !== ex) begin errors++; $display("FAIL bb_state%0d: got %b want %b", t, state, ex); end
      if (t == 3) begin
        checks++; if (in_rd_en !== 4'b1000) begin errors++; $display("FAIL bb_regrant: got %b want 1000", in_rd_en); end
      end
    end
    tick();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL bb_done_wr: got %b want 0", out_wr); end
  endtask

  initial begin
    reset    = 1'b1;
    out_rdy  = 1'b1;
    in_data  = '0;
    in_ctrl  = '0;
    in_empty = '1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_stall();
    test_late_header();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
